// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared overflow-tracker types and constants
package ariane_pkg;

    localparam int unsigned OM_RANGE_DEPTH = 8;
    localparam int unsigned OM_ADDR_W      = 32;

    // Inclusive heap interval; also used by the overflow tracker.
    typedef struct packed {
        logic [OM_ADDR_W-1:0] first;
        logic [OM_ADDR_W-1:0] last;
    } range_t;

    function automatic logic range_well_formed(input range_t r);
        return r.first <= r.last;
    endfunction

endpackage

// File: rtl/range_hit_encoder.sv
// rtl/range_hit_encoder.sv - parallel inclusive interval compare with lowest-index priority encode
module range_hit_encoder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] first,
    input  logic [DEPTH-1:0][ADDR_W-1:0] last,
    input  logic [ADDR_W-1:0]            addr,
    output logic                         hit,
    output logic [IDX_W-1:0]             hit_idx
);

    logic [DEPTH-1:0] hit_vec;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid[i] && (first[i] <= addr) && (addr <= last[i]);
        end
    end

    // Scan downward so the lowest hitting slot is the one that sticks.
    always_comb begin
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = i[IDX_W-1:0];
            end
        end
    end

    assign hit = |hit_vec;

endmodule

// File: rtl/overflow_range_store.sv
// rtl/overflow_range_store.sv - circular store of suspicious address intervals with same-cycle lookup
module overflow_range_store
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH  = OM_RANGE_DEPTH,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = IDX_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_first_i,
    input  logic [ADDR_W-1:0] wr_last_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  hit_idx_o,
    output logic [ADDR_W-1:0] last_first_o,
    output logic [ADDR_W-1:0] last_last_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              overwrite_o,
    output logic              reject_o
);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] first_q;
    logic [DEPTH-1:0][ADDR_W-1:0] last_q;
    logic [IDX_W-1:0]             wr_ptr_q;
    logic [CNT_W-1:0]             count_q;
    logic                         overwrite_q;
    logic                         reject_q;

    logic             full;
    logic             well_formed;
    logic             duplicate;
    logic             store;
    logic [IDX_W-1:0] newest_idx;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign well_formed = (wr_first_i <= wr_last_i);

    always_comb begin
        duplicate = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && first_q[i] == wr_first_i && last_q[i] == wr_last_i) begin
                duplicate = 1'b1;
            end
        end
    end

    // A duplicate is accepted but changes nothing, so it never stores.
    assign store = wr_en_i && well_formed && !duplicate;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            first_q     <= '0;
            last_q      <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overwrite_q <= 1'b0;
            reject_q    <= 1'b0;
        end else if (clear_i) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overwrite_q <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            overwrite_q <= 1'b0;
            reject_q    <= wr_en_i && !well_formed;
            if (store) begin
                first_q[wr_ptr_q] <= wr_first_i;
                last_q[wr_ptr_q]  <= wr_last_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + IDX_W'(1);
                // When full the pointer already sits on the oldest slot.
                if (full) begin
                    overwrite_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    assign newest_idx = wr_ptr_q - IDX_W'(1);

    always_comb begin
        last_first_o = '0;
        last_last_o  = '0;
        if (count_q != '0) begin
            last_first_o = first_q[newest_idx];
            last_last_o  = last_q[newest_idx];
        end
    end

    range_hit_encoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_hit_encoder (
        .valid   (valid_q),
        .first   (first_q),
        .last    (last_q),
        .addr    (lookup_addr_i),
        .hit     (hit_o),
        .hit_idx (hit_idx_o)
    );

    assign count_o     = count_q;
    assign full_o      = full;
    assign overwrite_o = overwrite_q;
    assign reject_o    = reject_q;

endmodule

// File: tb/tb_overflow_range_store.sv
// tb/tb_overflow_range_store.sv - table-driven bench for overflow_range_store
module tb_overflow_range_store;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        wr_en_i;
    logic [31:0] wr_first_i;
    logic [31:0] wr_last_i;
    logic [31:0] lookup_addr_i;
    logic        hit_o;
    logic [2:0]  hit_idx_o;
    logic [31:0] last_first_o;
    logic [31:0] last_last_o;
    logic [3:0]  count_o;
    logic        full_o;
    logic        overwrite_o;
    logic        reject_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    overflow_range_store #(
        .DEPTH  (8),
        .ADDR_W (32)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .wr_en_i       (wr_en_i),
        .wr_first_i    (wr_first_i),
        .wr_last_i     (wr_last_i),
        .lookup_addr_i (lookup_addr_i),
        .hit_o         (hit_o),
        .hit_idx_o     (hit_idx_o),
        .last_first_o  (last_first_o),
        .last_last_o   (last_last_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .overwrite_o   (overwrite_o),
        .reject_o      (reject_o)
    );

    typedef struct {
        logic        clr;
        logic        we;
        logic [31:0] first;
        logic [31:0] last;
        logic [31:0] lk;
        logic        hit;
        logic [2:0]  idx;
        logic [3:0]  cnt;
        logic        full;
        logic        ovf;
        logic        rej;
        logic [31:0] lf;
        logic [31:0] ll;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic we, input logic [31:0] first,
                       input logic [31:0] last, input logic [31:0] lk, input logic hit,
                       input logic [2:0] idx, input logic [3:0] cnt, input logic full,
                       input logic ovf, input logic rej, input logic [31:0] lf,
                       input logic [31:0] ll);
        vec_t v;
        v.clr = clr; v.we = we; v.first = first; v.last = last; v.lk = lk;
        v.hit = hit; v.idx = idx; v.cnt = cnt; v.full = full; v.ovf = ovf;
        v.rej = rej; v.lf = lf; v.ll = ll;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input int step, input logic hit, input logic [2:0] idx,
                             input logic [3:0] cnt, input logic full, input logic ovf,
                             input logic rej, input logic [31:0] lf, input logic [31:0] ll);
        chk("hit", step, 32'(hit_o), 32'(hit));
        chk("hit_idx", step, 32'(hit_idx_o), 32'(idx));
        chk("count", step, 32'(count_o), 32'(cnt));
        chk("full", step, 32'(full_o), 32'(full));
        chk("overwrite", step, 32'(overwrite_o), 32'(ovf));
        chk("reject", step, 32'(reject_o), 32'(rej));
        chk("last_first", step, last_first_o, lf);
        chk("last_last", step, last_last_o, ll);
    endtask

    initial begin
        // clr we first         last          lookup        hit idx cnt full ovf rej lf            ll
        add(0, 1, 32'h8000_0100, 32'h8000_0140, 32'h8000_0140, 1, 0, 1, 0, 0, 0, 32'h8000_0100, 32'h8000_0140);
        add(0, 0, 32'h0,         32'h0,         32'h8000_0141, 0, 0, 1, 0, 0, 0, 32'h8000_0100, 32'h8000_0140);
        add(1, 0, 32'h0,         32'h0,         32'h8000_0100, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        add(0, 1, 32'h1000, 32'h1020, 32'h1010, 1, 0, 1, 0, 0, 0, 32'h1000, 32'h1020);
        add(0, 1, 32'h2000, 32'h2020, 32'h2010, 1, 1, 2, 0, 0, 0, 32'h2000, 32'h2020);
        add(0, 1, 32'h3000, 32'h3020, 32'h3010, 1, 2, 3, 0, 0, 0, 32'h3000, 32'h3020);
        add(0, 1, 32'h4000, 32'h4020, 32'h4010, 1, 3, 4, 0, 0, 0, 32'h4000, 32'h4020);
        add(0, 1, 32'h5000, 32'h5020, 32'h5010, 1, 4, 5, 0, 0, 0, 32'h5000, 32'h5020);
        add(0, 1, 32'h6000, 32'h6020, 32'h6010, 1, 5, 6, 0, 0, 0, 32'h6000, 32'h6020);
        add(0, 1, 32'h7000, 32'h7020, 32'h7010, 1, 6, 7, 0, 0, 0, 32'h7000, 32'h7020);
        add(0, 1, 32'h8000, 32'h8020, 32'h1010, 1, 0, 8, 1, 0, 0, 32'h8000, 32'h8020);
        add(0, 1, 32'h9000, 32'h9020, 32'h1010, 0, 0, 8, 1, 1, 0, 32'h9000, 32'h9020);
        add(0, 0, 32'h0,    32'h0,    32'h9010, 1, 0, 8, 1, 0, 0, 32'h9000, 32'h9020);
        add(0, 0, 32'h0,    32'h0,    32'h8010, 1, 7, 8, 1, 0, 0, 32'h9000, 32'h9020);
        add(1, 0, 32'h0,    32'h0,    32'h9010, 0, 0, 0, 0, 0, 0, 32'h0,    32'h0);
        add(0, 1, 32'h300,  32'h300,  32'h300,  1, 0, 1, 0, 0, 0, 32'h300,  32'h300);
        add(0, 1, 32'h200,  32'h100,  32'h300,  1, 0, 1, 0, 0, 1, 32'h300,  32'h300);
        add(0, 0, 32'h0,    32'h0,    32'h150,  0, 0, 1, 0, 0, 0, 32'h300,  32'h300);
        add(1, 0, 32'h0,    32'h0,    32'h0,    0, 0, 0, 0, 0, 0, 32'h0,    32'h0);
        add(0, 1, 32'h400,  32'h480,  32'h400,  1, 0, 1, 0, 0, 0, 32'h400,  32'h480);
        add(0, 1, 32'h400,  32'h480,  32'h480,  1, 0, 1, 0, 0, 0, 32'h400,  32'h480);
        add(0, 0, 32'h0,    32'h0,    32'h481,  0, 0, 1, 0, 0, 0, 32'h400,  32'h480);
        add(1, 0, 32'h0,    32'h0,    32'h0,    0, 0, 0, 0, 0, 0, 32'h0,    32'h0);
        add(0, 1, 32'h500,  32'h5FF,  32'h590,  1, 0, 1, 0, 0, 0, 32'h500,  32'h5FF);
        add(0, 1, 32'h580,  32'h680,  32'h590,  1, 0, 2, 0, 0, 0, 32'h580,  32'h680);
        add(0, 0, 32'h0,    32'h0,    32'h650,  1, 1, 2, 0, 0, 0, 32'h580,  32'h680);
        add(0, 0, 32'h0,    32'h0,    32'h681,  0, 0, 2, 0, 0, 0, 32'h580,  32'h680);
        add(0, 0, 32'h0,    32'h0,    32'h4FF,  0, 0, 2, 0, 0, 0, 32'h580,  32'h680);
        add(0, 1, 32'h700,  32'h710,  32'h705,  1, 2, 3, 0, 0, 0, 32'h700,  32'h710);
        add(1, 1, 32'h800,  32'h810,  32'h500,  0, 0, 0, 0, 0, 0, 32'h0,    32'h0);
        add(0, 0, 32'h0,    32'h0,    32'h800,  0, 0, 0, 0, 0, 0, 32'h0,    32'h0);
        add(0, 1, 32'hA00,  32'hA10,  32'hA00,  1, 0, 1, 0, 0, 0, 32'hA00,  32'hA10);
        add(0, 1, 32'hB00,  32'hB10,  32'hB05,  1, 1, 2, 0, 0, 0, 32'hB00,  32'hB10);

        rst_ni = 1'b0; clear_i = 1'b0; wr_en_i = 1'b0;
        wr_first_i = '0; wr_last_i = '0; lookup_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all(-1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int s = 0; s < vecs.size(); s++) begin
            @(negedge clk_i);
            clear_i       = vecs[s].clr;
            wr_en_i       = vecs[s].we;
            wr_first_i    = vecs[s].first;
            wr_last_i     = vecs[s].last;
            lookup_addr_i = vecs[s].lk;
            @(posedge clk_i);
            #1;
            check_all(s, vecs[s].hit, vecs[s].idx, vecs[s].cnt, vecs[s].full,
                      vecs[s].ovf, vecs[s].rej, vecs[s].lf, vecs[s].ll);
        end

        // A write and a lookup of the same address in one cycle see the old contents.
        @(negedge clk_i);
        clear_i = 1'b0; wr_en_i = 1'b1;
        wr_first_i = 32'hC00; wr_last_i = 32'hC10; lookup_addr_i = 32'hC08;
        #1;
        chk("no_bypass_hit", 100, 32'(hit_o), 32'h0);
        @(posedge clk_i);
        #1;
        chk("after_write_hit", 101, 32'(hit_o), 32'h1);
        chk("after_write_idx", 101, 32'(hit_idx_o), 32'h2);

        // Asynchronous reset mid-cycle clears everything without a clock edge.
        @(negedge clk_i);
        wr_en_i = 1'b0; wr_first_i = 32'h900; wr_last_i = 32'h9FF;
        lookup_addr_i = 32'hA05;
        #2;
        rst_ni = 1'b0;
        #1;
        check_all(102, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wr_en_i = 1'b1;
        lookup_addr_i = 32'h950;
        @(posedge clk_i);
        #1;
        check_all(103, 1, 0, 1, 0, 0, 0, 32'h900, 32'h9FF);
        @(negedge clk_i);
        wr_en_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/overflow_range_store.md
# overflow_range_store

Circular store of suspicious heap address intervals `[first, last]` produced by the byte-store overflow tracker in the execute stage. Each interval is a run of contiguous `SB` writes that the tracker has judged to be an overflow. The block keeps the most recent `DEPTH` intervals and answers a same-cycle membership query for every load address, which the tracker uses to flag out-of-range loads. When full, the oldest interval is overwritten, so tracking continues indefinitely.

## Interface
- `DEPTH`, 8, number of interval slots; must be a power of two, ≥ 2.
- `ADDR_W`, 32, address width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset: asynchronous, active-low.
- `clear_i`  in  1  synchronous flush of all entries (user reset of the store).
- `wr_en_i`  in  1  write strobe; one interval per cycle.
- `wr_first_i`  in  ADDR_W  interval start, inclusive.
- `wr_last_i`  in  ADDR_W  interval end, inclusive.
- `lookup_addr_i`  in  ADDR_W  address to test.
- `hit_o`  out  1  `lookup_addr_i` lies inside any valid entry (combinational).
- `hit_idx_o`  out  $clog2(DEPTH)  lowest-index hitting slot; 0 when no hit.
- `last_first_o`  out  ADDR_W  start of the most recently written entry; 0 when empty.
- `last_last_o`  out  ADDR_W  end of the most recently written entry; 0 when empty.
- `count_o`  out  $clog2(DEPTH)+1  number of valid entries.
- `full_o`  out  1  `count_o == DEPTH`.
- `overwrite_o`  out  1  one-cycle pulse: previous cycle's write evicted the oldest entry.
- `reject_o`  out  1  one-cycle pulse: previous cycle's write was malformed (`first > last`) and was dropped.

## Operation
- State per slot: `valid`, `first`, `last`. Global state: write pointer `wr_ptr`, `count`.
- Write accepted when `wr_en_i && !clear_i && wr_first_i <= wr_last_i` (unsigned compare).
  - Store the interval at `wr_ptr`.
  - Set the slot's `valid`.
  - `wr_ptr <= wr_ptr + 1` modulo DEPTH (natural wrap).
- Count update on an accepted write:
  - Not full: `count` increments.
  - Full: `count` stays at DEPTH, the slot overwritten is the oldest, and `overwrite_o` is asserted on the next cycle.
- Duplicate: if a valid slot already holds identical first/last, the write is accepted as a no-op. The pointer, count and slots are unchanged, and no `overwrite_o` is asserted.
- Malformed write (`first > last`) is dropped and `reject_o` is asserted on the next cycle. A single-byte interval (`first == last`) is legal.
- `clear_i` takes effect on the next clock edge:
  - Clears all `valid` bits, `wr_ptr`, `count`, and both pulses.
  - Has priority over a simultaneous write.
- Lookup:
  - Per slot, `hit[i] = valid[i] && first[i] <= lookup_addr_i && lookup_addr_i <= last[i]`, all unsigned.
  - `hit_o = |hit`.
  - `hit_idx_o` is the priority encode of `hit`, lowest index first.
- `last_first_o` / `last_last_o` come from slot `wr_ptr - 1` (mod DEPTH) when `count != 0`, else 0.
- Reset values: every output is 0, all slots invalid, `wr_ptr = 0`.

## Timing
- Lookup path is purely combinational from `lookup_addr_i` and registered state: zero latency, usable in the same cycle as the load.
- A write at edge N is visible to lookups, `count_o`, `full_o` and the `last_*` outputs from cycle N+1. A lookup in the same cycle as the write sees the old contents; there is no write-to-lookup bypass.
- `overwrite_o` and `reject_o` are registered, high for exactly one cycle after the causing edge.
- Reset asserted mid-operation: state clears immediately (asynchronous); the first write after deassertion goes to slot 0.
- No backpressure: a write every cycle is always accepted.

## Structure
- A `range_t` struct `{logic [ADDR_W-1:0] first; logic [ADDR_W-1:0] last;}` and a default depth constant `OM_RANGE_DEPTH = 8` go in `ariane_pkg`, shared with the overflow tracker.
- Sub-module `range_hit_encoder` contains:
  - DEPTH parallel inclusive comparators;
  - the priority encoder producing `hit_o` / `hit_idx_o`.
- The top level holds the slot registers, pointer, counter and pulse flops.

## Test plan
- Reset, then write `[0x8000_0100, 0x8000_0140]`:
  - cycle+1: `count_o = 1`, `last_first_o = 0x8000_0100`, `last_last_o = 0x8000_0140`;
  - lookup `0x8000_0140` → `hit_o = 1`, `hit_idx_o = 0`;
  - lookup `0x8000_0141` → `hit_o = 0`.
- Write 9 distinct intervals `[0x1000*k, 0x1000*k + 0x20]`, k = 1..9, with DEPTH = 8:
  - `full_o = 1` after the 8th write;
  - `overwrite_o` pulses once, after the 9th write;
  - lookup `0x1010` → miss; lookup `0x9010` → `hit_idx_o = 0`.
- Write `[0x200, 0x100]` → `reject_o` pulses for one cycle and `count_o` is unchanged; write `[0x300, 0x300]` → lookup `0x300` hits.
- Write `[0x400, 0x480]` twice → `count_o = 1`, no `overwrite_o` pulse.
- Overlapping intervals `[0x500, 0x5FF]` in slot 0 and `[0x580, 0x680]` in slot 1: lookup `0x590` → `hit_idx_o = 0`; lookup `0x650` → `hit_idx_o = 1`.
- `clear_i` asserted together with `wr_en_i` while `count_o = 3` → next cycle `count_o = 0` and no hits; separately, `rst_ni` pulsed mid-stream → all outputs read 0 immediately.
